// File: rtl/multi_bank_rotating_buffer.sv
// Round-robin N-bank staging buffer feeding the matmul feeders; each full bank may be replayed.
// Compile-time option: RBUF_REPLAY_EN honours READ_PASSES, otherwise every bank is read exactly once.
module multi_bank_rotating_buffer #(
    parameter int DATA_WIDTH  = 16,
    parameter int NUM_CH      = 4,
    parameter int DEPTH       = 16,
    parameter int NUM_BANKS   = 2,
    parameter int READ_PASSES = 1
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           flush_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_data_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [NUM_CH*DATA_WIDTH-1:0]   out_data_o,
    output logic                           out_last_o,
    output logic [$clog2(NUM_BANKS)-1:0]   out_bank_o,
    output logic [$clog2(NUM_BANKS+1)-1:0] full_cnt_o
);
    localparam int W  = NUM_CH * DATA_WIDTH;
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(NUM_BANKS);
    localparam int CW = $clog2(NUM_BANKS + 1);

    typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_st_e;
    typedef enum logic {R_IDLE, R_RUN} rd_st_e;

    logic [W-1:0]  mem_q [NUM_BANKS][DEPTH];
    bank_st_e      status_q [NUM_BANKS];
    bank_st_e      status_d [NUM_BANKS];
    logic [BW-1:0] wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
    logic [AW-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    rd_st_e        rd_state_q, rd_state_d;
    logic          rd_done_q, rd_done_d;
    logic          out_valid_q, out_valid_d;
    logic          out_last_q, out_last_d;
    logic [W-1:0]  out_data_q, out_data_d;
    logic [BW-1:0] out_bank_q, out_bank_d;
    logic [CW-1:0] full_cnt_q, full_cnt_d;
    logic          wr_fire, wr_wrap, rd_wrap, fetch, rd_release, last_pass;

`ifdef RBUF_REPLAY_EN
    localparam int PASSES = READ_PASSES;
    localparam int PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
    logic [PW-1:0] pass_q, pass_d;
    assign last_pass = (pass_q == PW'(PASSES - 1));
`else
    logic unused_passes;
    assign unused_passes = |READ_PASSES;
    assign last_pass     = 1'b1;
`endif

    function automatic logic [BW-1:0] bank_inc(input logic [BW-1:0] b);
        return (b == BW'(NUM_BANKS - 1)) ? '0 : b + 1'b1;
    endfunction

    // Ready comes only from registered status, so a release never collides with a fill.
    assign in_ready_o = (status_q[wr_bank_q] == B_EMPTY) || (status_q[wr_bank_q] == B_FILLING);
    assign wr_fire    = in_valid_i && in_ready_o && !flush_i;
    assign wr_wrap    = (wr_addr_q == AW'(DEPTH - 1));
    assign rd_wrap    = (rd_addr_q == AW'(DEPTH - 1));
    assign fetch      = (rd_state_q == R_RUN) && !rd_done_q && (!out_valid_q || out_ready_i);
    // rd_done_q marks the final beat sitting in the output register; release waits for its acceptance.
    assign rd_release = (rd_state_q == R_RUN) && rd_done_q && out_valid_q && out_ready_i;

    always_comb begin
        status_d    = status_q;
        wr_bank_d   = wr_bank_q;
        wr_addr_d   = wr_addr_q;
        rd_bank_d   = rd_bank_q;
        rd_addr_d   = rd_addr_q;
        rd_state_d  = rd_state_q;
        rd_done_d   = rd_done_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        out_data_d  = out_data_q;
        out_bank_d  = out_bank_q;
        full_cnt_d  = full_cnt_q + CW'(wr_fire && wr_wrap) - CW'(rd_release);
`ifdef RBUF_REPLAY_EN
        pass_d      = pass_q;
`endif

        if (wr_fire) begin
            status_d[wr_bank_q] = wr_wrap ? B_FULL : B_FILLING;
            wr_addr_d           = wr_wrap ? '0 : wr_addr_q + 1'b1;
            if (wr_wrap) wr_bank_d = bank_inc(wr_bank_q);
        end

        case (rd_state_q)
            R_IDLE: begin
                if (status_q[rd_bank_q] == B_FULL) begin
                    status_d[rd_bank_q] = B_DRAINING;
                    rd_state_d          = R_RUN;
                    rd_addr_d           = '0;
`ifdef RBUF_REPLAY_EN
                    pass_d              = '0;
`endif
                end
            end
            R_RUN: begin
                if (fetch) begin
                    rd_addr_d = rd_wrap ? '0 : rd_addr_q + 1'b1;
                    if (rd_wrap) begin
                        if (last_pass) rd_done_d = 1'b1;
`ifdef RBUF_REPLAY_EN
                        else pass_d = pass_q + 1'b1;
`endif
                    end
                end
                if (rd_release) begin
                    status_d[rd_bank_q] = B_EMPTY;
                    rd_bank_d           = bank_inc(rd_bank_q);
                    rd_state_d          = R_IDLE;
                    rd_done_d           = 1'b0;
                end
            end
            default: rd_state_d = R_IDLE;
        endcase

        if (fetch) begin
            out_valid_d = 1'b1;
            out_data_d  = mem_q[rd_bank_q][rd_addr_q];
            out_last_d  = rd_wrap;
            out_bank_d  = rd_bank_q;
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end

        if (flush_i) begin
            for (int i = 0; i < NUM_BANKS; i++) status_d[i] = B_EMPTY;
            wr_bank_d   = '0;
            wr_addr_d   = '0;
            rd_bank_d   = '0;
            rd_addr_d   = '0;
            rd_state_d  = R_IDLE;
            rd_done_d   = 1'b0;
            out_valid_d = 1'b0;
            full_cnt_d  = '0;
`ifdef RBUF_REPLAY_EN
            pass_d      = '0;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_fire) mem_q[wr_bank_q][wr_addr_q] <= in_data_i;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NUM_BANKS; i++) status_q[i] <= B_EMPTY;
            wr_bank_q   <= '0;
            wr_addr_q   <= '0;
            rd_bank_q   <= '0;
            rd_addr_q   <= '0;
            rd_state_q  <= R_IDLE;
            rd_done_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
            out_bank_q  <= '0;
            full_cnt_q  <= '0;
`ifdef RBUF_REPLAY_EN
            pass_q      <= '0;
`endif
        end else begin
            status_q    <= status_d;
            wr_bank_q   <= wr_bank_d;
            wr_addr_q   <= wr_addr_d;
            rd_bank_q   <= rd_bank_d;
            rd_addr_q   <= rd_addr_d;
            rd_state_q  <= rd_state_d;
            rd_done_q   <= rd_done_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            out_data_q  <= out_data_d;
            out_bank_q  <= out_bank_d;
            full_cnt_q  <= full_cnt_d;
`ifdef RBUF_REPLAY_EN
            pass_q      <= pass_d;
`endif
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_data_o  = out_data_q;
    assign out_last_o  = out_last_q;
    assign out_bank_o  = out_bank_q;
    assign full_cnt_o  = full_cnt_q;

endmodule

// File: tb/tb_multi_bank_rotating_buffer.sv
// Randomized bench for multi_bank_rotating_buffer against a bank-sequence scoreboard model.
// Honours RBUF_REPLAY_EN the same way the design does (replay count 3 vs 1).
module tb_multi_bank_rotating_buffer;
    localparam int DW = 16, NCH = 2, D = 8, NB = 3, RP = 3;
    localparam int W = DW * NCH;
`ifdef RBUF_REPLAY_EN
    localparam int EFF = RP;
`else
    localparam int EFF = 1;
`endif

    logic          clk = 1'b0, rst_n = 1'b1, flush = 1'b0;
    logic          in_valid = 1'b0, out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready_o, out_valid_o, out_last_o;
    logic [W-1:0]  out_data_o;
    logic [1:0]    out_bank_o, full_cnt_o;

    always #5 clk = ~clk;

    multi_bank_rotating_buffer #(
        .DATA_WIDTH(DW), .NUM_CH(NCH), .DEPTH(D), .NUM_BANKS(NB), .READ_PASSES(RP)
    ) u_dut (
        .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready_o), .in_data_i(in_data),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready), .out_data_o(out_data_o),
        .out_last_o(out_last_o), .out_bank_o(out_bank_o), .full_cnt_o(full_cnt_o)
    );

    typedef struct { logic [W-1:0] d; logic last; logic [1:0] bank; logic rel; } beat_t;

    // Model: completed banks expand into their expected beat stream; occupancy is filled - released.
    beat_t        exp_q[$];
    logic [W-1:0] fill_buf[$];
    int           filled = 0, released = 0, bank_seq = 0;
    int           n_chk = 0, n_err = 0;
    logic         stall_q = 1'b0, seen_valid = 1'b0;
    logic [W-1:0] st_data;
    logic         st_last;
    logic [1:0]   st_bank;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic exp_ready();
        return (filled - released) < NB;
    endfunction

    task automatic model_clear();
        exp_q.delete();
        fill_buf.delete();
        filled = 0; released = 0; bank_seq = 0;
        stall_q = 1'b0;
    endtask

    task automatic model_push(input logic [W-1:0] d);
        beat_t b;
        fill_buf.push_back(d);
        if (fill_buf.size() == D) begin
            for (int p = 0; p < EFF; p++)
                for (int a = 0; a < D; a++) begin
                    b.d = fill_buf[a];
                    b.last = (a == D - 1);
                    b.bank = 2'(bank_seq);
                    b.rel = (a == D - 1) && (p == EFF - 1);
                    exp_q.push_back(b);
                end
            bank_seq = (bank_seq + 1) % NB;
            filled++;
            fill_buf.delete();
        end
    endtask

    // One clock: check at negedge, advance model at posedge, return 1 time unit later.
    task automatic step();
        logic wf, rf;
        @(negedge clk);
        chk("in_ready", 64'(in_ready_o), 64'(exp_ready()));
        chk("full_cnt", 64'(full_cnt_o), 64'(filled - released));
        if (stall_q) begin
            chk("stall_valid", 64'(out_valid_o), 64'(1));
            chk("stall_data", 64'(out_data_o), 64'(st_data));
            chk("stall_last", 64'(out_last_o), 64'(st_last));
            chk("stall_bank", 64'(out_bank_o), 64'(st_bank));
        end
        seen_valid = out_valid_o;
        if (out_valid_o) begin
            if (exp_q.size() == 0) chk("out_unexpected", 64'(out_valid_o), 64'(0));
            else begin
                chk("out_data", 64'(out_data_o), 64'(exp_q[0].d));
                chk("out_last", 64'(out_last_o), 64'(exp_q[0].last));
                chk("out_bank", 64'(out_bank_o), 64'(exp_q[0].bank));
            end
        end
        wf = in_valid && exp_ready() && !flush;
        rf = out_valid_o && out_ready && !flush && (exp_q.size() > 0);
        stall_q = out_valid_o && !out_ready && !flush;
        st_data = out_data_o; st_last = out_last_o; st_bank = out_bank_o;
        @(posedge clk);
        if (flush) model_clear();
        else begin
            if (wf) model_push(in_data);
            if (rf) begin
                if (exp_q[0].rel) released++;
                void'(exp_q.pop_front());
            end
        end
        #1;
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        in_valid = 1'b0; out_ready = 1'b1;
        while (exp_q.size() > 0 && guard < 2000) begin step(); guard++; end
        chk(tag, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_in_ready"}, 64'(in_ready_o), 64'(1));
        chk({tag, "_out_valid"}, 64'(out_valid_o), 64'(0));
        chk({tag, "_out_data"}, 64'(out_data_o), 64'(0));
        chk({tag, "_out_last"}, 64'(out_last_o), 64'(0));
        chk({tag, "_out_bank"}, 64'(out_bank_o), 64'(0));
        chk({tag, "_full_cnt"}, 64'(full_cnt_o), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, steps, drops;
        #1 rst_n = 1'b0;
        #2 reset_vals("rst0");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Fill every bank with the consumer stalled, then offer junk that must be ignored.
        out_ready = 1'b0;
        for (int i = 0; i < NB * D; i++) begin in_valid = 1'b1; in_data = W'(i); step(); end
        in_data = 32'hDEAD_BEEF;
        repeat (3) step();
        chk("all_full_cnt", 64'(full_cnt_o), 64'(NB));
        chk("all_full_ready", 64'(in_ready_o), 64'(0));
        drain("drain_fill");

        // Single bank: first-beat latency and bubble-free replay.
        out_ready = 1'b1;
        for (int i = 0; i < D; i++) begin in_valid = 1'b1; in_data = W'(10 + i); step(); end
        in_valid = 1'b0;
        lat = 0;
        do begin step(); lat++; end while (!seen_valid && lat < 20);
        chk("first_latency", 64'(lat), 64'(3));
        steps = 1;
        while (exp_q.size() > 0 && steps < 200) begin step(); steps++; end
        chk("drain_cycles", 64'(steps), 64'(D * EFF));

        // Backpressure: strict toggle, then fully random handshakes.
        for (int i = 0; i < 80; i++) begin
            in_valid = 1'b1; in_data = $urandom; out_ready = i[0]; step();
        end
        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 3) != 0); in_data = $urandom;
            out_ready = ($urandom_range(0, 1) != 0); step();
        end
        drain("drain_rand");

        // Concurrent streaming.
        drops = 0;
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1; out_ready = 1'b1; in_data = $urandom;
            drops += (in_ready_o ? 0 : 1);
            step();
        end
`ifndef RBUF_REPLAY_EN
        chk("stream_ready_drop", 64'(drops), 64'(0));
`endif
        drain("drain_stream");
        flush = 1'b1; step(); flush = 1'b0;

        // Flush while bank 0 drains and bank 1 holds two beats.
        out_ready = 1'b1;
        for (int i = 0; i < D + 2; i++) begin in_valid = 1'b1; in_data = W'(100 + i); step(); end
        flush = 1'b1; in_data = $urandom; step(); flush = 1'b0;
        chk("flush_out_valid", 64'(out_valid_o), 64'(0));
        chk("flush_full_cnt", 64'(full_cnt_o), 64'(0));
        chk("flush_in_ready", 64'(in_ready_o), 64'(1));
        for (int i = 0; i < D; i++) begin in_valid = 1'b1; in_data = W'(200 + i); step(); end
        drain("drain_flush");

        // Asynchronous reset in the middle of a drain.
        for (int i = 0; i < D; i++) begin in_valid = 1'b1; in_data = $urandom; step(); end
        in_valid = 1'b0;
        repeat (5) step();
        #1 rst_n = 1'b0;
        #1 reset_vals("rst_mid");
        model_clear();
        rst_n = 1'b1;
        for (int i = 0; i < 150; i++) begin
            in_valid = ($urandom_range(0, 3) != 0); in_data = $urandom;
            out_ready = ($urandom_range(0, 2) != 0); step();
        end
        drain("drain_after_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
